// File: rtl/rate_decoder_pkg.sv
// rate_decoder_pkg: state encoding, speed codes and default rates shared with the rate divider.
package rate_decoder_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_e;

    localparam logic [1:0] SPD_1  = 2'b00;
    localparam logic [1:0] SPD_5  = 2'b01;
    localparam logic [1:0] SPD_10 = 2'b10;
    localparam logic [1:0] SPD_20 = 2'b11;

    localparam int DEF_RATE0   = 1;
    localparam int DEF_RATE1   = 5;
    localparam int DEF_RATE2   = 10;
    localparam int DEF_RATE3   = 20;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rate_decoder_timer.sv
// pulse_interval_timer: cycles since the last pulse, saturating at TIMEOUT-1, with interval and timeout flag.
module pulse_interval_timer #(
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 64
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse_i,
    output logic [CNT_W-1:0] m_o,
    output logic             timeout_o
);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d     = pulse_i ? '0 : (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
    assign m_o       = cnt_q + 1'b1;
    assign timeout_o = (cnt_q == TMAX) && !pulse_i;

    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/rate_decoder.sv
// rate_decoder: recovers the speed code of a rate-divider pulse train by exact interval matching,
// locking after LOCK_CNT consecutive equal codes.
module rate_decoder
    import rate_decoder_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int RATE0    = DEF_RATE0,
    parameter int RATE1    = DEF_RATE1,
    parameter int RATE2    = DEF_RATE2,
    parameter int RATE3    = DEF_RATE3,
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = DEF_TIMEOUT
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [1:0]       speed,
    output logic             locked,
    output logic             mismatch,
    output logic [CNT_W-1:0] interval
);
    state_e           state_q;
    logic [2:0]       streak_q;
    logic [1:0]       cand_q, speed_q, code;
    logic             locked_q, mismatch_q, hit, timeout, lock_now, same;
    logic [CNT_W-1:0] interval_q, m;
    logic [3:0]       nstreak;

    pulse_interval_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .pulse_i   (pulse_in),
        .m_o       (m),
        .timeout_o (timeout)
    );

    assign hit  = m == CNT_W'(RATE0) || m == CNT_W'(RATE1) || m == CNT_W'(RATE2) || m == CNT_W'(RATE3);
    assign code = (m == CNT_W'(RATE0)) ? SPD_1 :
                  (m == CNT_W'(RATE1)) ? SPD_5 :
                  (m == CNT_W'(RATE2)) ? SPD_10 : SPD_20;
    // a new candidate code restarts the streak at one, so LOCK_CNT==1 locks on it directly
    assign nstreak  = (code == cand_q) ? {1'b0, streak_q} + 4'd1 : 4'd1;
    assign lock_now = nstreak >= 4'(LOCK_CNT);
    assign same     = hit && code == speed_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            cand_q     <= '0;
            speed_q    <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            interval_q <= '0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (pulse_in) begin
                        state_q  <= ARMED;
                        streak_q <= '0;
                    end
                ARMED:
                    if (pulse_in) begin
                        interval_q <= m;
                        if (!hit) begin
                            mismatch_q <= 1'b1;
                            streak_q   <= '0;
                        end else begin
                            cand_q <= code;
                            if (lock_now) begin
                                state_q  <= LOCKED;
                                speed_q  <= code;
                                locked_q <= 1'b1;
                                streak_q <= '0;
                            end else
                                streak_q <= nstreak[2:0];
                        end
                    end else if (timeout) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        streak_q <= '0;
                    end
                LOCKED:
                    if (pulse_in) begin
                        interval_q <= m;
                        if (!same) begin
                            state_q    <= ARMED;
                            mismatch_q <= 1'b1;
                            locked_q   <= 1'b0;
                            streak_q   <= hit ? 3'd1 : 3'd0;
                            if (hit) cand_q <= code;
                        end
                    end else if (timeout) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        streak_q <= '0;
                    end
                default: state_q <= IDLE;
            endcase
        end

    assign speed    = speed_q;
    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign interval = interval_q;

endmodule

// File: tb/tb_rate_decoder.sv
// tb_rate_decoder: scoreboard bench; expected {speed,locked,mismatch,interval} words are queued
// with the edge they are due on and compared 1 time unit after that edge.
module tb_rate_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pulse_in = 1'b0;
    logic [1:0]  speed;
    logic        locked, mismatch;
    logic [25:0] interval;

    typedef struct {
        int          due;
        string       tag;
        logic [29:0] exp;
    } exp_t;

    exp_t sb[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    rate_decoder dut (
        .clock    (clock),
        .reset    (reset),
        .pulse_in (pulse_in),
        .speed    (speed),
        .locked   (locked),
        .mismatch (mismatch),
        .interval (interval)
    );

    always #5 clock = ~clock;

    function automatic logic [29:0] pk(input logic [1:0] s, input logic l, input logic mm, input int iv);
        return {s, l, mm, 26'(iv)};
    endfunction

    function automatic logic [29:0] obs();
        return {speed, locked, mismatch, interval};
    endfunction

    task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got spd/lk/mm/iv=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                     tag, got[29:28], got[27], got[26], got[25:0], exp[29:28], exp[27], exp[26], exp[25:0]);
        end
    endtask

    task automatic tick(input logic p);
        pulse_in = p;
        @(posedge clock);
        #1;
        edges++;
        while (sb.size() > 0 && sb[0].due <= edges) begin
            exp_t e = sb.pop_front();
            chk(e.tag, (e.due == edges) ? obs() : ~e.exp, e.exp);
        end
    endtask

    task automatic exp_at(input int k, input string tag, input logic [29:0] e);
        sb.push_back('{due: edges + k, tag: tag, exp: e});
    endtask

    task automatic pa(input int n, input string tag, input logic [29:0] e);
        exp_at(n, tag, e);
        repeat (n - 1) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_state", obs(), pk(2'b00, 0, 0, 0));
        do_reset();

        // rate 5 locks after three pulses
        tick(1'b1);
        pa(5, "r5_first", pk(2'b00, 0, 0, 5));
        pa(5, "r5_lock", pk(2'b01, 1, 0, 5));

        // pulse held high: interval 1 locks on the third pulse
        do_reset();
        exp_at(2, "hold_p2", pk(2'b00, 0, 0, 1));
        exp_at(3, "hold_lock", pk(2'b00, 1, 0, 1));
        exp_at(4, "hold_p4", pk(2'b00, 1, 0, 1));
        repeat (4) tick(1'b1);

        // locked at 10, a 7-cycle interval breaks lock, two 10s relock
        do_reset();
        tick(1'b1);
        pa(10, "r10_first", pk(2'b00, 0, 0, 10));
        pa(10, "r10_lock", pk(2'b10, 1, 0, 10));
        pa(7, "r10_break", pk(2'b10, 0, 1, 7));
        exp_at(1, "r10_mm_clear", pk(2'b10, 0, 0, 7));
        pa(10, "r10_re1", pk(2'b10, 0, 0, 10));
        pa(10, "r10_relock", pk(2'b10, 1, 0, 10));

        // locked at 20, then silence until timeout
        do_reset();
        tick(1'b1);
        pa(20, "r20_first", pk(2'b00, 0, 0, 20));
        pa(20, "r20_lock", pk(2'b11, 1, 0, 20));
        exp_at(63, "to_before", pk(2'b11, 1, 0, 20));
        exp_at(64, "to_drop", pk(2'b11, 0, 0, 20));
        repeat (74) tick(1'b0);
        exp_at(1, "to_idle_pulse", pk(2'b11, 0, 0, 20));
        tick(1'b1);
        pa(10, "to_armed", pk(2'b11, 0, 0, 10));
        pa(64, "to_same_cycle", pk(2'b11, 0, 1, 64));
        exp_at(1, "to_mm_clear", pk(2'b11, 0, 0, 64));
        tick(1'b0);

        // locked at 5, switch to 20-cycle spacing
        do_reset();
        tick(1'b1);
        pa(5, "sw_first", pk(2'b00, 0, 0, 5));
        pa(5, "sw_lock5", pk(2'b01, 1, 0, 5));
        pa(20, "sw_break", pk(2'b01, 0, 1, 20));
        pa(20, "sw_lock20", pk(2'b11, 1, 0, 20));

        // asynchronous reset between edges while locked
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", obs(), pk(2'b00, 0, 0, 0));
        tick(1'b0);
        reset = 1'b0;
        exp_at(1, "post_rst_idle", pk(2'b00, 0, 0, 0));
        tick(1'b1);
        pa(5, "post_rst_armed", pk(2'b00, 0, 0, 5));

        chk("sb_drained", 30'(sb.size()), 30'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
